// File: rtl/ws2812_rx_decoder.sv
// WS2812 800 kHz single-wire receiver: pulse-width bit decode, 24-bit GRB words, reset-gap frame end.
// Optional WS_RX_FORWARD_EN adds the dout port that passes the line on after the first pixel of a frame.
`timescale 1ns/1ps

module ws2812_rx_decoder #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BIT_THRESH = 30,
    parameter int MIN_HIGH   = 5,
    parameter int MAX_HIGH   = 75,
    parameter int RESET_CLKS = CLK_HZ / 20_000   // 50 us of low time
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_end,
    output logic [15:0] frame_pixels,
    output logic        rx_err
`ifdef WS_RX_FORWARD_EN
    ,
    output logic        dout
`endif
);

    localparam logic [1:0] S_SYNC = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    localparam logic [6:0]  THRESH_H = 7'(BIT_THRESH);
    localparam logic [6:0]  MIN_H    = 7'(MIN_HIGH);
    localparam logic [6:0]  MAX_H    = 7'(MAX_HIGH);
    localparam logic [11:0] GAP_L    = 12'(RESET_CLKS);

    logic        din_meta, din_s, din_d;
    logic        rise, fall;
    logic [1:0]  state;
    logic [6:0]  hcnt, hcnt_inc;
    logic [11:0] lcnt, lcnt_inc;
    logic [4:0]  bit_cnt;
    logic [23:0] shreg, shifted;
    logic [15:0] pix_cnt, pix_cnt_inc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
            din_d    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
            din_d    <= din_s;
        end
    end

    assign rise        = din_s & ~din_d;
    assign fall        = ~din_s & din_d;
    assign hcnt_inc    = (&hcnt) ? hcnt : hcnt + 7'd1;
    assign lcnt_inc    = (&lcnt) ? lcnt : lcnt + 12'd1;
    assign pix_cnt_inc = (&pix_cnt) ? pix_cnt : pix_cnt + 16'd1;
    assign shifted     = {shreg[22:0], (hcnt >= THRESH_H)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_SYNC;
            hcnt         <= '0;
            lcnt         <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            pix_cnt      <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            frame_end    <= 1'b0;
            frame_pixels <= '0;
            rx_err       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_end   <= 1'b0;
            rx_err      <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (din_s)               lcnt  <= '0;
                    else if (lcnt == GAP_L)  state <= S_IDLE;
                    else                     lcnt  <= lcnt_inc;
                end
                S_IDLE: begin
                    if (rise) begin
                        state <= S_HIGH;
                        hcnt  <= 7'd1;
                    end
                end
                S_HIGH: begin
                    // Glitches and over-long highs both abandon the word and resync on a gap.
                    if ((fall && hcnt < MIN_H) || (!fall && hcnt > MAX_H)) begin
                        rx_err  <= 1'b1;
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                        lcnt    <= '0;
                        state   <= S_SYNC;
                    end else if (fall) begin
                        shreg <= shifted;
                        lcnt  <= 12'd1;
                        state <= S_LOW;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt     <= '0;
                            pixel_data  <= shifted;
                            pixel_valid <= 1'b1;
                            pix_cnt     <= pix_cnt_inc;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else begin
                        hcnt <= hcnt_inc;
                    end
                end
                default: begin // S_LOW
                    if (rise) begin
                        state <= S_HIGH;
                        hcnt  <= 7'd1;
                    end else if (lcnt == GAP_L) begin
                        frame_end    <= 1'b1;
                        frame_pixels <= pix_cnt;
                        rx_err       <= (bit_cnt != 5'd0);
                        pix_cnt      <= '0;
                        bit_cnt      <= '0;
                        state        <= S_IDLE;
                    end else begin
                        lcnt <= lcnt_inc;
                    end
                end
            endcase
        end
    end

`ifdef WS_RX_FORWARD_EN
    logic fwd;

    // Once this block has consumed its own pixel, the rest of the frame passes downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        fwd <= 1'b0;
        else if (frame_end || rx_err)   fwd <= 1'b0;
        else if (pixel_valid)           fwd <= 1'b1;
    end

    assign dout = fwd & din_s;
`endif

endmodule
